// File: rtl/adder4_pkg.sv
// Shared constants, FSM state encoding and delay-line payload for the Adder_4 scheduler.
package adder4_pkg;

    localparam int unsigned DATA_W           = 24;
    localparam int unsigned TAG_W            = 4;
    localparam int unsigned SHIFT_DEPTH_DEF  = 6;
    localparam int unsigned STARVE_LIMIT_DEF = 8;

    localparam int unsigned KQ = 3329;
    localparam int unsigned DQ = 8380417;

    localparam logic MODE_KADD = 1'b0;
    localparam logic MODE_DSUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SHIFTED,
        ST_DRAIN
    } state_t;

    // Fields of a shifted op that must wait for the adder's delayed a-path
    typedef struct packed {
        logic [DATA_W-1:0] b;
        logic              mode;
        logic [TAG_W-1:0]  tag;
        logic              src;
    } dly_entry_t;

endpackage

// File: rtl/adder4_sched_dly.sv
// Delay line that re-times b/mode/tag/src of shifted ops to meet the adder's delayed a.
// DEPTH must be at least 2.
module adder4_sched_dly
    import adder4_pkg::*;
#(
    parameter int unsigned DEPTH = SHIFT_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  dly_entry_t in_data,
    output logic       out_valid,
    output dly_entry_t out_data,
    output logic       empty
);

    logic [DEPTH-1:0] vld_q;
    dly_entry_t       data_q [DEPTH];

    // Only the valid bits need reset; payload is qualified by them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int i = 1; i < int'(DEPTH); i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign empty     = ~|vld_q;

endmodule

// File: rtl/adder4_sched.sv
// Two-requester scheduler for one shared Adder_4: arbitration, d2ntt b-alignment
// and tagged registered results.
module adder4_sched
    import adder4_pkg::*;
#(
    parameter int unsigned SHIFT_DEPTH  = SHIFT_DEPTH_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic [DATA_W-1:0] rq0_a,
    input  logic [DATA_W-1:0] rq0_b,
    input  logic              rq0_mode,
    input  logic              rq0_d2ntt,
    input  logic [TAG_W-1:0]  rq0_tag,
    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic [DATA_W-1:0] rq1_a,
    input  logic [DATA_W-1:0] rq1_b,
    input  logic              rq1_mode,
    input  logic              rq1_d2ntt,
    input  logic [TAG_W-1:0]  rq1_tag,
    output logic [DATA_W-1:0] ad_a,
    output logic [DATA_W-1:0] ad_b,
    output logic              ad_mode,
    output logic              ad_sel_d2ntt,
    input  logic [DATA_W-1:0] ad_sum,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_src
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    state_t            state_q, state_d;
    logic              rr_q;
    logic [CNT_W-1:0]  cnt_q [2];
    logic [DATA_W-1:0] a_q, b_q;
    logic              mode_q;

    logic [1:0]        valid, d2ntt, blocked, starved, compat, grant;
    logic              issue, gidx, g_mode, g_d2ntt;
    logic [DATA_W-1:0] g_a, g_b;
    logic [TAG_W-1:0]  g_tag;

    dly_entry_t        dly_in, dly_out;
    logic              dly_in_valid, dly_out_valid, dly_empty;

    adder4_sched_dly #(.DEPTH(SHIFT_DEPTH)) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (dly_in_valid),
        .in_data   (dly_in),
        .out_valid (dly_out_valid),
        .out_data  (dly_out),
        .empty     (dly_empty)
    );

    // Grant selection, next state and adder drive
    always_comb begin
        valid   = {rq1_valid, rq0_valid};
        d2ntt   = {rq1_d2ntt, rq0_d2ntt};
        blocked = '0;
        compat  = '0;
        state_d = state_q;

        case (state_q)
            ST_IDLE:    compat = valid;
            ST_DIRECT:  begin
                compat  = valid & ~d2ntt;
                blocked = valid & d2ntt;
            end
            ST_SHIFTED: begin
                compat  = valid & d2ntt;
                blocked = valid & ~d2ntt;
            end
            default:    compat = '0;
        endcase

        // A starved requester freezes grants until IDLE, where it wins outright
        starved = {rq1_valid && (cnt_q[1] >= CNT_W'(STARVE_LIMIT)),
                   rq0_valid && (cnt_q[0] >= CNT_W'(STARVE_LIMIT))};
        if (starved != 2'b00) begin
            compat = (state_q == ST_IDLE) ? starved : 2'b00;
        end
        if (!rst) begin
            compat = '0;
        end

        grant   = (compat == 2'b11) ? (rr_q ? 2'b10 : 2'b01) : compat;
        issue   = |grant;
        gidx    = grant[1];
        g_a     = gidx ? rq1_a     : rq0_a;
        g_b     = gidx ? rq1_b     : rq0_b;
        g_mode  = gidx ? rq1_mode  : rq0_mode;
        g_d2ntt = gidx ? rq1_d2ntt : rq0_d2ntt;
        g_tag   = gidx ? rq1_tag   : rq0_tag;

        case (state_q)
            ST_IDLE:    if (issue) state_d = g_d2ntt ? ST_SHIFTED : ST_DIRECT;
            ST_DIRECT:  if (!issue) state_d = ST_IDLE;
            ST_SHIFTED: if (!issue) state_d = ST_DRAIN;
            ST_DRAIN:   if (dly_empty) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        dly_in_valid = issue && g_d2ntt;
        dly_in       = '{b: g_b, mode: g_mode, tag: g_tag, src: gidx};

        // Completing shifted op owns b/mode; otherwise a direct issue, else hold
        ad_a    = issue ? g_a : a_q;
        ad_b    = b_q;
        ad_mode = mode_q;
        if (dly_out_valid) begin
            ad_b    = dly_out.b;
            ad_mode = dly_out.mode;
        end else if (issue && !g_d2ntt) begin
            ad_b    = g_b;
            ad_mode = g_mode;
        end

        ad_sel_d2ntt = (state_q == ST_SHIFTED) || (state_q == ST_DRAIN) || (issue && g_d2ntt);
        rq0_ready    = grant[0];
        rq1_ready    = grant[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            res_src   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                rr_q <= ~gidx;
            end
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    cnt_q[i] <= '0;
                end else if (blocked[i] && (cnt_q[i] < CNT_W'(STARVE_LIMIT))) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
            a_q       <= ad_a;
            b_q       <= ad_b;
            mode_q    <= ad_mode;
            res_valid <= dly_out_valid || (issue && !g_d2ntt);
            res_data  <= ad_sum;
            res_tag   <= dly_out_valid ? dly_out.tag : g_tag;
            res_src   <= dly_out_valid ? dly_out.src : gidx;
        end
    end

endmodule

// File: tb/tb_adder4_sched.sv
// Directed bench for adder4_sched with a behavioural Adder_4 (incl. its delayed a-path).
module tb_adder4_sched;
    import adder4_pkg::*;

    localparam int unsigned SD = SHIFT_DEPTH_DEF;

    typedef struct packed {
        logic              src;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } res_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              rq0_valid, rq0_ready, rq0_mode, rq0_d2ntt;
    logic [DATA_W-1:0] rq0_a, rq0_b;
    logic [TAG_W-1:0]  rq0_tag;
    logic              rq1_valid, rq1_ready, rq1_mode, rq1_d2ntt;
    logic [DATA_W-1:0] rq1_a, rq1_b;
    logic [TAG_W-1:0]  rq1_tag;
    logic [DATA_W-1:0] ad_a, ad_b, ad_sum, res_data;
    logic              ad_mode, ad_sel_d2ntt, res_valid, res_src;
    logic [TAG_W-1:0]  res_tag;

    int   checks = 0;
    int   failures = 0;
    int   wait_n, acc1, j0, j1;
    res_t res_q[$];
    logic [DATA_W-1:0] a_hist [SD];

    always #5 clk = ~clk;

    adder4_sched dut (
        .clk(clk), .rst(rst),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_a(rq0_a), .rq0_b(rq0_b),
        .rq0_mode(rq0_mode), .rq0_d2ntt(rq0_d2ntt), .rq0_tag(rq0_tag),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_a(rq1_a), .rq1_b(rq1_b),
        .rq1_mode(rq1_mode), .rq1_d2ntt(rq1_d2ntt), .rq1_tag(rq1_tag),
        .ad_a(ad_a), .ad_b(ad_b), .ad_mode(ad_mode), .ad_sel_d2ntt(ad_sel_d2ntt),
        .ad_sum(ad_sum),
        .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag), .res_src(res_src)
    );

    // Adder_4 model: dual 12-bit add mod Kq, or 24-bit sub mod Dq
    function automatic logic [DATA_W-1:0] adder_model(input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b,
                                                      input logic mode);
        int unsigned hi, lo;
        if (mode == MODE_KADD) begin
            hi = (32'(a[23:12]) + 32'(b[23:12])) % KQ;
            lo = (32'(a[11:0]) + 32'(b[11:0])) % KQ;
            return {12'(hi), 12'(lo)};
        end
        if (a >= b) return a - b;
        return DATA_W'(DQ - (32'(b) - 32'(a)));
    endfunction

    always @(posedge clk) begin
        a_hist[0] <= ad_a;
        for (int i = 1; i < int'(SD); i++) a_hist[i] <= a_hist[i-1];
    end

    always_comb ad_sum = adder_model(ad_sel_d2ntt ? a_hist[SD-1] : ad_a, ad_b, ad_mode);

    always @(negedge clk) begin
        if (res_valid) res_q.push_back('{src: res_src, tag: res_tag, data: res_data});
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic mode, input logic d2, input logic [TAG_W-1:0] tag);
        rq0_valid = v; rq0_a = a; rq0_b = b; rq0_mode = mode; rq0_d2ntt = d2; rq0_tag = tag;
    endtask

    task automatic drive1(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic mode, input logic d2, input logic [TAG_W-1:0] tag);
        rq1_valid = v; rq1_a = a; rq1_b = b; rq1_mode = mode; rq1_d2ntt = d2; rq1_tag = tag;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: a valid request must not be accepted, outputs all 0
        rst = 1'b0;
        drive0(1'b1, 24'h123456, 24'h654321, 1'b1, 1'b0, 4'h1);
        drive1(1'b0, '0, '0, 1'b0, 1'b0, '0);
        repeat (2) next_cycle();
        sample();
        check_eq("rst_ready0", 32'(rq0_ready), 32'd0);
        check_eq("rst_ad_a", 32'(ad_a), 32'd0);
        check_eq("rst_ad_b", 32'(ad_b), 32'd0);
        check_eq("rst_sel", 32'(ad_sel_d2ntt), 32'd0);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        next_cycle();
        drive0(1'b0, '0, '0, 1'b0, 1'b0, '0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // T1: direct Kyber add, result one cycle after issue
        drive0(1'b1, 24'hD00001, 24'h001002, MODE_KADD, 1'b0, 4'h3);
        sample();
        check_eq("t1_ready0", 32'(rq0_ready), 32'd1);
        check_eq("t1_ad_a", 32'(ad_a), 32'hD00001);
        check_eq("t1_ad_b", 32'(ad_b), 32'h001002);
        check_eq("t1_sel", 32'(ad_sel_d2ntt), 32'd0);
        next_cycle();
        drive0(1'b0, '0, '0, 1'b0, 1'b0, '0);
        sample();
        check_eq("t1_res_valid", 32'(res_valid), 32'd1);
        check_eq("t1_res_data", 32'(res_data), 32'h000003);
        check_eq("t1_res_tag", 32'(res_tag), 32'h3);
        check_eq("t1_res_src", 32'(res_src), 32'd0);
        check_eq("t1_ad_a_hold", 32'(ad_a), 32'hD00001);
        next_cycle();
        sample();
        check_eq("t1_res_pulse", 32'(res_valid), 32'd0);
        next_cycle();

        // T2: shifted Dilithium sub, b aligned SD cycles later
        drive1(1'b1, 24'd5, 24'd7, MODE_DSUB, 1'b1, 4'h9);
        sample();
        check_eq("t2_ready1", 32'(rq1_ready), 32'd1);
        check_eq("t2_sel_t", 32'(ad_sel_d2ntt), 32'd1);
        check_eq("t2_ad_a", 32'(ad_a), 32'd5);
        res_q.delete();
        next_cycle();
        drive1(1'b0, '0, '0, 1'b0, 1'b0, '0);
        repeat (SD - 1) begin
            sample();
            next_cycle();
        end
        sample();
        check_eq("t2_ad_b", 32'(ad_b), 32'd7);
        check_eq("t2_ad_mode", 32'(ad_mode), 32'd1);
        check_eq("t2_sel_t6", 32'(ad_sel_d2ntt), 32'd1);
        check_eq("t2_no_early_res", 32'(res_q.size()), 32'd0);
        next_cycle();
        sample();
        check_eq("t2_res_valid", 32'(res_valid), 32'd1);
        check_eq("t2_res_data", 32'(res_data), 32'd8380415);
        check_eq("t2_res_tag", 32'(res_tag), 32'h9);
        check_eq("t2_res_src", 32'(res_src), 32'd1);
        next_cycle();
        sample();
        check_eq("t2_sel_idle", 32'(ad_sel_d2ntt), 32'd0);
        next_cycle();

        // T3: six back-to-back shifted ops, then a direct op waits out the drain
        res_q.delete();
        for (int i = 0; i < 6; i++) begin
            drive1(1'b1, 24'(256 + i), 24'h80, MODE_DSUB, 1'b1, 4'(i));
            sample();
            check_eq("t3_ready1", 32'(rq1_ready), 32'd1);
            next_cycle();
        end
        drive1(1'b0, '0, '0, 1'b0, 1'b0, '0);
        drive0(1'b1, 24'h001002, 24'h003004, MODE_KADD, 1'b0, 4'h7);
        wait_n = 0;
        sample();
        while (!rq0_ready && wait_n < 20) begin
            wait_n++;
            next_cycle();
            sample();
        end
        check_eq("t3_wait", 32'(wait_n), 32'd7);
        check_eq("t3_sel", 32'(ad_sel_d2ntt), 32'd0);
        next_cycle();
        drive0(1'b0, '0, '0, 1'b0, 1'b0, '0);
        repeat (3) begin
            sample();
            next_cycle();
        end
        check_eq("t3_nres", 32'(res_q.size()), 32'd7);
        if (res_q.size() == 7) begin
            for (int i = 0; i < 6; i++) begin
                check_eq("t3_src", 32'(res_q[i].src), 32'd1);
                check_eq("t3_tag", 32'(res_q[i].tag), 32'(i));
                check_eq("t3_data", 32'(res_q[i].data), 32'(128 + i));
            end
            check_eq("t3_d_src", 32'(res_q[6].src), 32'd0);
            check_eq("t3_d_data", 32'(res_q[6].data), 32'h004006);
        end

        // Fresh reset so the round-robin pointer starts at requester 0
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // T4: both requesters direct and continuous -> strict alternation
        res_q.delete();
        j0 = 0;
        j1 = 0;
        for (int k = 0; k < 8; k++) begin
            drive0(1'b1, {12'(j0), 12'd1}, {12'd1, 12'(j0)}, MODE_KADD, 1'b0, 4'(j0));
            drive1(1'b1, 24'(1000 + j1), 24'(j1), MODE_DSUB, 1'b0, 4'(8 + j1));
            sample();
            check_eq("t4_ready0", 32'(rq0_ready), 32'(k % 2 == 0));
            check_eq("t4_ready1", 32'(rq1_ready), 32'(k % 2 == 1));
            if (rq0_ready) j0++;
            if (rq1_ready) j1++;
            next_cycle();
        end
        drive0(1'b0, '0, '0, 1'b0, 1'b0, '0);
        drive1(1'b0, '0, '0, 1'b0, 1'b0, '0);
        repeat (2) begin
            sample();
            next_cycle();
        end
        check_eq("t4_nres", 32'(res_q.size()), 32'd8);
        if (res_q.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check_eq("t4_src", 32'(res_q[k].src), 32'(k % 2));
                check_eq("t4_tag", 32'(res_q[k].tag), (k % 2 == 0) ? 32'(k / 2) : 32'(8 + k / 2));
                check_eq("t4_data", 32'(res_q[k].data),
                         (k % 2 == 0) ? 32'({12'(k / 2 + 1), 12'(k / 2 + 1)}) : 32'd1000);
            end
        end

        // T5: rq1 streams shifted ops; waiting direct rq0 forces a drain
        res_q.delete();
        j1 = 0;
        drive1(1'b1, 24'(512 + j1), 24'h100, MODE_DSUB, 1'b1, 4'(j1));
        sample();
        check_eq("t5_first1", 32'(rq1_ready), 32'd1);
        j1++;
        next_cycle();
        drive0(1'b1, 24'h00A00B, 24'h001001, MODE_KADD, 1'b0, 4'h5);
        wait_n = 0;
        acc1 = 0;
        while (wait_n < 40) begin
            drive1(1'b1, 24'(512 + j1), 24'h100, MODE_DSUB, 1'b1, 4'(j1));
            sample();
            if (rq0_ready) break;
            if (rq1_ready) begin
                acc1++;
                j1++;
            end
            wait_n++;
            next_cycle();
        end
        check_eq("t5_wait", 32'(wait_n), 32'd15);
        check_eq("t5_rq1_issues", 32'(acc1), 32'd8);
        check_eq("t5_ready1_blocked", 32'(rq1_ready), 32'd0);
        check_eq("t5_ad_a", 32'(ad_a), 32'h00A00B);
        next_cycle();
        drive0(1'b0, '0, '0, 1'b0, 1'b0, '0);
        drive1(1'b0, '0, '0, 1'b0, 1'b0, '0);
        repeat (3) begin
            sample();
            next_cycle();
        end
        check_eq("t5_nres", 32'(res_q.size()), 32'd10);
        if (res_q.size() == 10) begin
            check_eq("t5_first_data", 32'(res_q[0].data), 32'h100);
            check_eq("t5_last1_tag", 32'(res_q[8].tag), 32'd8);
            check_eq("t5_last1_data", 32'(res_q[8].data), 32'h108);
            check_eq("t5_rq0_src", 32'(res_q[9].src), 32'd0);
            check_eq("t5_rq0_tag", 32'(res_q[9].tag), 32'h5);
            check_eq("t5_rq0_data", 32'(res_q[9].data), 32'h00B00C);
        end

        // T6: reset in the middle of a shifted op flushes it
        drive1(1'b1, 24'd3, 24'd1, MODE_DSUB, 1'b1, 4'hC);
        sample();
        check_eq("t6_ready1", 32'(rq1_ready), 32'd1);
        next_cycle();
        drive1(1'b0, '0, '0, 1'b0, 1'b0, '0);
        res_q.delete();
        repeat (2) next_cycle();
        rst = 1'b0;
        #1;
        check_eq("t6_sel", 32'(ad_sel_d2ntt), 32'd0);
        check_eq("t6_ad_a", 32'(ad_a), 32'd0);
        check_eq("t6_ad_b", 32'(ad_b), 32'd0);
        check_eq("t6_ad_mode", 32'(ad_mode), 32'd0);
        check_eq("t6_res_valid", 32'(res_valid), 32'd0);
        check_eq("t6_res_data", 32'(res_data), 32'd0);
        check_eq("t6_res_tag", 32'(res_tag), 32'd0);
        check_eq("t6_res_src", 32'(res_src), 32'd0);
        next_cycle();
        rst = 1'b1;
        repeat (10) begin
            sample();
            next_cycle();
        end
        check_eq("t6_no_res", 32'(res_q.size()), 32'd0);
        check_eq("t6_sel_after", 32'(ad_sel_d2ntt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
